intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//  Interrupt controller sitting directly upstream of the single-cycle datapath's exception logic.
//  Captures rising edges on external sources into pending bits and applies a mask.
//  Picks the lowest-index unmasked pending source and drives the CPU 'intr' request.
//  On the CPU 'inta' acknowledge, latches the winner as in-service and supplies a cause word.
//  Holds further requests until the handler signals end-of-interrupt.
// PARAMETERS
//  N_SRC   8   number of interrupt sources, legal range 1..8
//  ID_W    3   width of irq_id, legal range 1..3; must satisfy 2**ID_W >= N_SRC
// PORTS
//  clk       in   1      system clock, all state on posedge
//  reset     in   1      asynchronous, active-low reset
//  irq_src   in   N_SRC  raw interrupt lines, rising edge = request
//  inta      in   1      CPU interrupt acknowledge, 1-cycle pulse
//  eoi       in   1      end-of-interrupt from handler, 1-cycle pulse
//  mask_we   in   1      mask register write enable
//  mask_in   in   N_SRC  new mask; 1 = source disabled
//  mask_out  out  N_SRC  current mask register
//  pending   out  N_SRC  pending bits
//  intr      out  1      interrupt request to CPU, registered
//  irq_id    out  ID_W   in REQ: current winner; in SERVICE: in-service id
//  cause     out  32     [15:8] one-hot in-service source (zero-extended); all other bits 0
//  busy      out  1      1 while in SERVICE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; pending, mask, intr, irq_id, cause, busy = 0;
//   edge-detect history = 0; sync flops (if present) = 0.
//  Edge detect: pending[i] sets the cycle after a 0->1 transition of the (synchronised) source.
//   A level held high does not re-trigger.
//  Pending clear: only the acknowledged bit clears, on the inta cycle.
//   Edge and clear on the same bit in the same cycle: set wins, bit stays 1.
//  Mask: written on mask_we, visible from the next cycle. Masked bits still latch pending.
//  req_vec = pending & ~mask. Winner = lowest index set in req_vec.
//  FSM:
//   IDLE:    if |req_vec -> REQ, intr<=1.
//   REQ:     intr=1; irq_id follows the live winner.
//            inta -> SERVICE: intr<=0, busy<=1, irq_id and cause latched from winner, winner pending cleared.
//            Else if req_vec==0 (masked off) -> IDLE, intr<=0.
//   SERVICE: intr=0; irq_id and cause frozen. eoi -> IDLE: busy<=0, cause<=0.
//            New edges still latch into pending.
//  inta outside REQ is ignored. eoi outside SERVICE is ignored. inta and eoi together: the state rule applies.
//  Latency without sync: edge sampled at cycle t -> pending at t+1 -> intr at t+2.
//  After eoi with pending work: back-to-back cycle via IDLE, intr re-asserts 2 cycles after eoi.
//  Reset mid-service drops everything. Pending requests are lost, by design.
// CONFIGURATION
//  INTC_SYNC_EN defined: each irq_src passes a 2-flop synchroniser before edge detect.
//   Adds 2 cycles, so edge at t -> pending at t+3 -> intr at t+4.
//  INTC_SYNC_EN undefined: irq_src is edge-detected directly. Sources must already be synchronous to clk.
// TESTING (N_SRC=8, INTC_SYNC_EN undefined unless stated)
//  1. Release reset -> all outputs 0, mask_out=8'h00.
//     Pulse irq_src[3] -> pending=8'h08 next cycle, intr=1 one cycle later, irq_id=3.
//  2. Sources 5 and 2 rise in the same cycle -> irq_id=2.
//     inta -> pending=8'h20, cause=32'h0000_0400, busy=1, intr=0.
//     eoi -> intr re-asserts with irq_id=5 two cycles later.
//  3. mask_in=8'h01 written, then irq_src[0] rises -> pending=8'h01, intr stays 0.
//     Write mask=8'h00 -> intr=1 two cycles later.
//  4. In REQ for source 4, write mask=8'h10 -> intr falls next cycle, state IDLE, pending[4] still 1.
//  5. In SERVICE for id 1, irq_src[1] rises again -> pending[1]=1, intr stays 0 until eoi.
//     Spurious inta in SERVICE and eoi in IDLE -> no state change.
//  6. Assert reset low in SERVICE -> all outputs 0 immediately (async).
//     Repeat test 1 with INTC_SYNC_EN -> intr at edge+4 cycles.

Source files
------------

// File: rtl/intr_ctrl.sv
// Edge-triggered, maskable, fixed-priority interrupt controller with an IDLE/REQ/SERVICE handshake.
// Optional macro INTC_SYNC_EN adds a 2-flop synchroniser on every irq_src line.
module intr_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             inta,
  input  logic             eoi,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_in,
  output logic [N_SRC-1:0] mask_out,
  output logic [N_SRC-1:0] pending,
  output logic             intr,
  output logic [ID_W-1:0]  irq_id,
  output logic [31:0]      cause,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [N_SRC-1:0] w_src;
  logic [N_SRC-1:0] r_hist;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] w_req_vec;
  logic [N_SRC-1:0] w_onehot;
  logic [N_SRC-1:0] w_clr;
  logic [ID_W-1:0]  w_winner;
  logic             w_any;
  logic [7:0]       w_onehot8;
  logic             r_intr;
  logic             w_intr_nx;
  logic             r_busy;
  logic             w_busy_nx;
  logic [31:0]      r_cause;
  logic [31:0]      w_cause_nx;
  logic [ID_W-1:0]  r_irq_id;
  logic [ID_W-1:0]  w_irq_id_nx;

`ifdef INTC_SYNC_EN
  logic [N_SRC-1:0] r_sync1;
  logic [N_SRC-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_src;
`endif

  assign w_rise    = w_src & ~r_hist;
  assign w_req_vec = r_pending & ~r_mask;
  assign w_any     = |w_req_vec;
  assign w_onehot8 = 8'(w_onehot);
  // Only the acknowledged winner is cleared; a simultaneous new edge re-sets it below.
  assign w_clr     = ((r_state == ST_REQ) && inta) ? w_onehot : '0;

  always_comb begin
    w_winner = '0;
    w_onehot = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_req_vec[i]) begin
        w_winner    = ID_W'(i);
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
      end else begin
        w_winner = w_winner;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist    <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_hist    <= w_src;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) begin
        r_mask <= mask_in;
      end
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_intr_nx   = r_intr;
    w_busy_nx   = r_busy;
    w_cause_nx  = r_cause;
    w_irq_id_nx = r_irq_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nx = ST_REQ;
          w_intr_nx  = 1'b1;
        end else begin
          w_intr_nx  = 1'b0;
        end
      end
      ST_REQ: begin
        if (inta && w_any) begin
          w_state_nx  = ST_SERVICE;
          w_intr_nx   = 1'b0;
          w_busy_nx   = 1'b1;
          w_irq_id_nx = w_winner;
          w_cause_nx  = {16'h0000, w_onehot8, 8'h00};
        end else if (!w_any) begin
          w_state_nx = ST_IDLE;
          w_intr_nx  = 1'b0;
        end else begin
          w_intr_nx  = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          w_state_nx = ST_IDLE;
          w_busy_nx  = 1'b0;
          w_cause_nx = 32'h0000_0000;
        end else begin
          w_state_nx = ST_SERVICE;
        end
      end
      default: begin
        w_state_nx  = ST_IDLE;
        w_intr_nx   = 1'b0;
        w_busy_nx   = 1'b0;
        w_cause_nx  = 32'h0000_0000;
        w_irq_id_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_intr   <= 1'b0;
      r_busy   <= 1'b0;
      r_cause  <= 32'h0000_0000;
      r_irq_id <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_intr   <= w_intr_nx;
      r_busy   <= w_busy_nx;
      r_cause  <= w_cause_nx;
      r_irq_id <= w_irq_id_nx;
    end
  end

  // While requesting, the id tracks the live winner so a newly arrived higher-priority source shows at once.
  assign irq_id   = (r_state == ST_REQ) ? w_winner : r_irq_id;
  assign intr     = r_intr;
  assign busy     = r_busy;
  assign cause    = r_cause;
  assign pending  = r_pending;
  assign mask_out = r_mask;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed, table-driven bench for intr_ctrl (default build, N_SRC=8, no synchroniser).
module tb_intr_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  irq_src;
  logic        inta;
  logic        eoi;
  logic        mask_we;
  logic [7:0]  mask_in;
  logic [7:0]  mask_out;
  logic [7:0]  pending;
  logic        intr;
  logic [2:0]  irq_id;
  logic [31:0] cause;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  src;
    logic        inta;
    logic        eoi;
    logic        mwe;
    logic [7:0]  min;
    logic [7:0]  pend;
    logic        intr;
    logic [2:0]  id;
    logic [31:0] cause;
    logic        busy;
    logic [7:0]  mask;
  } vec_t;

  vec_t vecs[$];

  intr_ctrl #(.N_SRC(8), .ID_W(3)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .inta(inta), .eoi(eoi),
    .mask_we(mask_we), .mask_in(mask_in), .mask_out(mask_out), .pending(pending),
    .intr(intr), .irq_id(irq_id), .cause(cause), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [7:0] src, input logic ia, input logic eo, input logic mwe,
                     input logic [7:0] min, input logic [7:0] pend, input logic it,
                     input logic [2:0] id, input logic [31:0] cs, input logic bz, input logic [7:0] mk);
    vec_t v;
    v.src = src; v.inta = ia; v.eoi = eo; v.mwe = mwe; v.min = min;
    v.pend = pend; v.intr = it; v.id = id; v.cause = cs; v.busy = bz; v.mask = mk;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pending"}, -1, {24'h0, pending}, 32'h0);
    chk({tag, "_mask"},    -1, {24'h0, mask_out}, 32'h0);
    chk({tag, "_intr"},    -1, {31'h0, intr}, 32'h0);
    chk({tag, "_irq_id"},  -1, {29'h0, irq_id}, 32'h0);
    chk({tag, "_cause"},   -1, cause, 32'h0);
    chk({tag, "_busy"},    -1, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    //   src    ia    eo    mwe   min    | pend   intr  id    cause         busy  mask
    // Single source 3: pending next cycle, intr one later
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h08, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 3'd3, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd3, 32'h0000_0800, 1'b1, 8'h00);
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd3, 32'h0000_0000, 1'b0, 8'h00);
    // Sources 5 and 2 together; held level must not re-trigger
    add(8'h24, 1'b0, 1'b0, 1'b0, 8'h00, 8'h24, 1'b0, 3'd3, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h24, 1'b0, 1'b0, 1'b0, 8'h00, 8'h24, 1'b1, 3'd2, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h24, 1'b1, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 3'd2, 32'h0000_0400, 1'b1, 8'h00);
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 1'b0, 3'd2, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 1'b1, 3'd5, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd5, 32'h0000_2000, 1'b1, 8'h00);
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd5, 32'h0000_0000, 1'b0, 8'h00);
    // Masked source still latches pending; unmasking raises intr two cycles later
    add(8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 3'd5, 32'h0000_0000, 1'b0, 8'h01);
    add(8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 3'd5, 32'h0000_0000, 1'b0, 8'h01);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 3'd5, 32'h0000_0000, 1'b0, 8'h01);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 3'd5, 32'h0000_0000, 1'b0, 8'h01);
    add(8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 3'd5, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 3'd0, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 32'h0000_0100, 1'b1, 8'h00);
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 8'h00);
    // Masking the only request while in REQ drops intr, pending kept
    add(8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b1, 3'd4, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 1'b1, 3'd0, 32'h0000_0000, 1'b0, 8'h10);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 8'h10);
    add(8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b1, 3'd4, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd4, 32'h0000_1000, 1'b1, 8'h00);
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd4, 32'h0000_0000, 1'b0, 8'h00);
    // Re-edge during SERVICE, spurious inta/eoi, inta+eoi together
    add(8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 3'd4, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 3'd1, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 32'h0000_0200, 1'b1, 8'h00);
    add(8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 3'd1, 32'h0000_0200, 1'b1, 8'h00);
    add(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 3'd1, 32'h0000_0200, 1'b1, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 3'd1, 32'h0000_0200, 1'b1, 8'h00);
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 3'd1, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 3'd1, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 32'h0000_0200, 1'b1, 8'h00);
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 32'h0000_0000, 1'b0, 8'h00);
    // New edge on the bit being acknowledged: set wins
    add(8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 3'd1, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 3'd1, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h02, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 3'd1, 32'h0000_0200, 1'b1, 8'h00);
    add(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 3'd1, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 3'd1, 32'h0000_0000, 1'b0, 8'h00);
    add(8'h00, 1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 1'b0, 3'd1, 32'h0000_0200, 1'b1, 8'h80);

    reset = 1'b0; irq_src = 8'h00; inta = 1'b0; eoi = 1'b0; mask_we = 1'b0; mask_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      irq_src = vecs[i].src; inta = vecs[i].inta; eoi = vecs[i].eoi;
      mask_we = vecs[i].mwe; mask_in = vecs[i].min;
      @(posedge clk);
      #1;
      chk("pending", i, {24'h0, pending},  {24'h0, vecs[i].pend});
      chk("intr",    i, {31'h0, intr},     {31'h0, vecs[i].intr});
      chk("irq_id",  i, {29'h0, irq_id},   {29'h0, vecs[i].id});
      chk("cause",   i, cause,             vecs[i].cause);
      chk("busy",    i, {31'h0, busy},     {31'h0, vecs[i].busy});
      chk("mask",    i, {24'h0, mask_out}, {24'h0, vecs[i].mask});
    end

    // Async reset in the middle of SERVICE clears outputs before the next clock edge
    #1;
    irq_src = 8'h00; inta = 1'b0; eoi = 1'b0; mask_we = 1'b0; mask_in = 8'h00;
    chk("pre_reset_busy", -1, {31'h0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
